// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg
//   Shared constants for the fetch front end.
//   Contents:
//     INST_ADDR_BUS_W / INST_BUS_W : default PC and instruction widths
//     RST_ENABLE / RST_DISABLE     : reset pin levels (active-high)
//     CHIP_ENABLE / CHIP_DISABLE   : instruction memory chip-enable levels
//     fetch_state_e                : front-end FSM encoding
package if_id_queue_pkg;

  localparam int unsigned INST_ADDR_BUS_W = 32;
  localparam int unsigned INST_BUS_W      = 32;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic RST_DISABLE  = 1'b0;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_REDIR = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_fifo.sv
// if_id_fifo
//   Synchronous DEPTH x WIDTH FIFO holding fetched {pc, inst} pairs.
//   The head entry is read straight out of register storage, so the
//   consumer never sees a combinational path from push_data.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high; empties and zeroes storage
//   push       in   write push_data at the tail (ignored when full without pop)
//   push_data  in   WIDTH-bit entry
//   pop        in   advance the head (ignored when empty)
//   flush      in   discard all entries
//   head_data  out  entry at the head
//   count      out  occupancy, 0..DEPTH
//   full       out  count == DEPTH
//   empty      out  count == 0
module if_id_fifo
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A push into a full queue is legal only when the head leaves in the
  // same cycle; the freed slot is exactly the one the tail wraps onto.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      // Collapse the tail onto the head rather than zeroing pointers so the
      // head storage (and therefore the ID outputs) keeps its last value.
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_id_queue.sv
// if_id_queue
//   Fetch front end: owns the PC, drives the instruction memory (combinational
//   read, same-cycle data) and buffers {pc, inst} pairs in a prefetch queue
//   handed to ID with a valid/ready handshake. Supports decode backpressure,
//   branch redirect with queue flush, and a fetch-enable gate.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | in reset, and the first cycle after reset is released
//   ST_RUN   | normal fetching
//   ST_REDIR | single dead cycle after a redirect; PC already retargeted
//
// Ports:
//   sys_clk         in   clock, rising edge
//   rstn            in   synchronous reset, active-high
//   fetch_en        in   1 = fetching allowed, 0 = hold PC
//   imem_ce         out  instruction memory chip enable
//   imem_addr       out  fetch address (current PC)
//   imem_inst       in   instruction for imem_addr, same cycle
//   redirect_valid  in   branch/jump redirect request
//   redirect_pc     in   redirect target
//   id_valid        out  queue head valid
//   id_ready        in   ID accepts the head this cycle
//   id_pc           out  PC of the head entry
//   id_inst         out  instruction of the head entry
//   q_count         out  queue occupancy
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned          ADDR_W   = INST_ADDR_BUS_W,
  parameter int unsigned          INST_W   = INST_BUS_W,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          PC_STEP  = 4
) (
  input  logic                     sys_clk,
  input  logic                     rstn,
  input  logic                     fetch_en,
  output logic                     imem_ce,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [INST_W-1:0]        imem_inst,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [ADDR_W-1:0]        id_pc,
  output logic [INST_W-1:0]        id_inst,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int unsigned ENTRY_W = ADDR_W + INST_W;

  fetch_state_e        state;
  logic [ADDR_W-1:0]   pc;
  logic                q_full;
  logic                q_empty;
  logic                deq;
  logic                fetch_go;
  logic [ENTRY_W-1:0]  head_entry;

  assign id_valid = !q_empty;
  assign deq      = id_valid && id_ready;

  // Fetch only in RUN, when allowed, with no redirect pending, and when the
  // queue has room now or gets it from a same-cycle dequeue.
  assign fetch_go = (rstn != RST_ENABLE) &&
                    (state == ST_RUN) &&
                    fetch_en &&
                    !redirect_valid &&
                    (!q_full || deq);

  assign imem_ce   = fetch_go ? CHIP_ENABLE : CHIP_DISABLE;
  assign imem_addr = pc;

  always_ff @(posedge sys_clk) begin
    if (rstn == RST_ENABLE) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
    end else if (redirect_valid) begin
      state <= ST_REDIR;
      pc    <= redirect_pc;
    end else begin
      case (state)
        ST_IDLE:  state <= ST_RUN;
        ST_RUN:   state <= ST_RUN;
        ST_REDIR: state <= ST_RUN;
        default:  state <= ST_IDLE;
      endcase
      if (fetch_go) begin
        pc <= pc + ADDR_W'(PC_STEP);
      end
    end
  end

  if_id_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (sys_clk),
    .rst       (rstn),
    .push      (fetch_go),
    .push_data ({pc, imem_inst}),
    .pop       (deq),
    .flush     (redirect_valid),
    .head_data (head_entry),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign id_pc   = head_entry[ENTRY_W-1:INST_W];
  assign id_inst = head_entry[INST_W-1:0];

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

  logic        sys_clk = 1'b0;
  logic        rstn;
  logic        fetch_en;
  logic        imem_ce;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [2:0]  q_count;

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // instruction memory: same-cycle combinational read
  assign imem_inst = inst_of(imem_addr);

  if_id_queue dut (
    .sys_clk        (sys_clk),
    .rstn           (rstn),
    .fetch_en       (fetch_en),
    .imem_ce        (imem_ce),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .q_count        (q_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to the next cycle; inputs are driven and outputs sampled 2ns after the edge
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rstn = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0;
    redirect_pc = '0; id_ready = 1'b1;
    cyc(3);

    // ---- reset state
    settle();
    chk("rst_ce",    imem_ce,   0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", id_valid,  0);
    chk("rst_cnt",   q_count,   0);
    chk("rst_idpc",  id_pc,     0);
    chk("rst_idinst",id_inst,   0);

    // ---- streaming with id_ready=1
    rstn = 1'b0; settle();
    chk("idle_ce", imem_ce, 0);
    cyc();
    settle();
    chk("s1_ce", imem_ce, 1); chk("s1_addr", imem_addr, 32'h0); chk("s1_valid", id_valid, 0);
    cyc(); settle();
    chk("s2_addr", imem_addr, 32'h4); chk("s2_idpc", id_pc, 32'h0);
    chk("s2_inst", id_inst, inst_of(32'h0)); chk("s2_cnt", q_count, 1);
    cyc(); settle();
    chk("s3_addr", imem_addr, 32'h8); chk("s3_idpc", id_pc, 32'h4); chk("s3_cnt", q_count, 1);
    cyc(); settle();
    chk("s4_idpc", id_pc, 32'h8); chk("s4_cnt", q_count, 1);

    // ---- backpressure until full
    rstn = 1'b1; cyc(2);
    rstn = 1'b0; id_ready = 1'b0;
    cyc(5); settle();
    chk("full_cnt", q_count, 4); chk("full_ce", imem_ce, 0);
    chk("full_addr", imem_addr, 32'h10); chk("full_idpc", id_pc, 32'h0);
    cyc(); settle();
    chk("full_hold_addr", imem_addr, 32'h10);
    id_ready = 1'b1; settle();
    chk("full_deq_ce", imem_ce, 1);
    cyc(); id_ready = 1'b0; settle();
    chk("full_deq_cnt", q_count, 4); chk("full_deq_idpc", id_pc, 32'h4);
    chk("full_deq_addr", imem_addr, 32'h14); chk("full_deq_ce2", imem_ce, 0);

    // ---- redirect with same-cycle handshake
    rstn = 1'b1; cyc(2);
    rstn = 1'b0;
    cyc(4); settle();
    chk("pre_redir_cnt", q_count, 3); chk("pre_redir_idpc", id_pc, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h100; id_ready = 1'b1; settle();
    chk("redir_ce", imem_ce, 0);
    cyc(); redirect_valid = 1'b0; settle();
    chk("redir_cnt", q_count, 0); chk("redir_valid", id_valid, 0);
    chk("redir_dead_ce", imem_ce, 0); chk("redir_addr", imem_addr, 32'h100);
    cyc(); settle();
    chk("redir_fetch_ce", imem_ce, 1); chk("redir_fetch_addr", imem_addr, 32'h100);
    cyc(); settle();
    chk("redir_idpc", id_pc, 32'h100); chk("redir_idinst", id_inst, inst_of(32'h100));
    chk("redir_cnt1", q_count, 1);

    // ---- PC wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; settle();
    cyc(); redirect_valid = 1'b0; id_ready = 1'b0; settle();
    chk("wrap_dead_ce", imem_ce, 0);
    cyc(); settle();
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC); chk("wrap_ce0", imem_ce, 1);
    cyc(); settle();
    chk("wrap_addr1", imem_addr, 32'h0); chk("wrap_idpc0", id_pc, 32'hFFFF_FFFC);
    id_ready = 1'b1;
    cyc(); settle();
    chk("wrap_idpc1", id_pc, 32'h0); chk("wrap_addr2", imem_addr, 32'h4);

    // ---- fetch_en=0 drain
    redirect_valid = 1'b1; redirect_pc = 32'h200; id_ready = 1'b0; settle();
    cyc(); redirect_valid = 1'b0;
    cyc(4); settle();
    chk("fe_cnt3", q_count, 3); chk("fe_addr", imem_addr, 32'h20C);
    fetch_en = 1'b0; id_ready = 1'b1; settle();
    chk("fe_off_ce", imem_ce, 0);
    cyc(); settle();
    chk("fe_d1_idpc", id_pc, 32'h204); chk("fe_d1_cnt", q_count, 2);
    cyc(); settle();
    chk("fe_d2_idpc", id_pc, 32'h208);
    cyc(); settle();
    chk("fe_empty_valid", id_valid, 0); chk("fe_empty_cnt", q_count, 0);
    cyc(); settle();
    chk("fe_frozen_addr", imem_addr, 32'h20C);
    fetch_en = 1'b1; settle();
    chk("fe_resume_ce", imem_ce, 1); chk("fe_resume_addr", imem_addr, 32'h20C);
    cyc(); settle();
    chk("fe_resume_idpc", id_pc, 32'h20C); chk("fe_resume_next", imem_addr, 32'h210);

    // ---- reset overrides redirect while full
    id_ready = 1'b0;
    cyc(3); settle();
    chk("rr_full_cnt", q_count, 4);
    rstn = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
    cyc(); redirect_valid = 1'b0; settle();
    chk("rr_addr", imem_addr, 32'h0); chk("rr_cnt", q_count, 0);
    chk("rr_valid", id_valid, 0); chk("rr_ce", imem_ce, 0);
    chk("rr_idpc", id_pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the fixed pc + if_id register pair.
- Holds the program counter and drives the instruction-memory controller: combinational read, same-cycle data.
- Buffers fetched {pc, inst} pairs in a DEPTH-entry prefetch queue with a valid/ready handshake towards ID.
- Adds what the current front end lacks: decode backpressure (stall), branch redirect with queue flush, and a fetch-enable gate.

Parameters:
- ADDR_W, 32: PC / instruction address width.
- INST_W, 32: instruction width.
- DEPTH, 4: prefetch queue entries; power of two, at least 2.
- RESET_PC, 0: PC value loaded on reset.
- PC_STEP, 4: PC increment per fetch.

Ports:
- sys_clk  in  1  single clock; all state updates on its rising edge.
- rstn  in  1  reset, synchronous, active-high (asserted = 1 resets on the next sys_clk edge).
- fetch_en  in  1  1 = fetching allowed; 0 = hold PC and issue no fetch.
- imem_ce  out  1  instruction memory chip enable.
- imem_addr  out  ADDR_W  fetch address (= current PC).
- imem_inst  in  INST_W  instruction returned in the same cycle as imem_ce/imem_addr.
- redirect_valid  in  1  branch/jump redirect request.
- redirect_pc  in  ADDR_W  redirect target; used as-is.
- id_valid  out  1  queue head holds a valid entry.
- id_ready  in  1  ID stage accepts the head this cycle.
- id_pc  out  ADDR_W  PC of the head entry.
- id_inst  out  INST_W  instruction of the head entry.
- q_count  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- States:
  - IDLE: entered while rstn=1 and for the first cycle after release.
  - RUN: normal fetching.
  - REDIR: the single cycle following a redirect.
- Transitions: IDLE->RUN the cycle after rstn deasserts; RUN->REDIR on redirect_valid; REDIR->RUN unconditionally. A redirect_valid seen in REDIR re-enters REDIR.
- Reset values:
  - pc=RESET_PC, imem_ce=0, queue empty.
  - id_valid=0, q_count=0.
  - id_pc=0, id_inst=0.
- imem_ce is 1 only when all hold: state==RUN, fetch_en=1, redirect_valid=0, and (q_count<DEPTH or a dequeue occurs this cycle).
- imem_addr = pc at all times; its value is don't-care when imem_ce=0.
- Enqueue: on a cycle with imem_ce=1, {pc, imem_inst} is written at the tail and pc <= pc+PC_STEP.
  - PC arithmetic is modulo 2^ADDR_W; wrap from all-ones region to 0 is legal.
- Dequeue: occurs when id_valid && id_ready. The head advances.
- id_pc/id_inst are driven from queue storage (registered), never combinationally from imem_inst.
  - Latency: an instruction fetched in cycle N is first visible at ID in cycle N+1.
- Simultaneous enqueue+dequeue when full: allowed; count stays DEPTH and no entry is lost.
- Simultaneous enqueue+dequeue when empty: the new entry appears next cycle; no bypass.
- Empty: id_valid=0; id_pc/id_inst hold their last values, with no guarantee beyond reset.
- Full: no fetch unless a dequeue happens in the same cycle; pc holds.
- Redirect (redirect_valid=1 in any state other than reset), highest priority:
  - A handshake in the same cycle still completes (ID consumed the head).
  - All entries are flushed at the edge: q_count=0, id_valid=0 next cycle.
  - pc <= redirect_pc; no fetch that cycle.
  - The following cycle (REDIR) has imem_ce=0; fetch of redirect_pc starts in the cycle after.
- fetch_en=0: queue keeps draining to ID; pc holds; re-enabling resumes at the held pc.
- Reset mid-operation: rstn=1 at any edge discards all entries and the state returns to IDLE, overriding redirect.
- Pointers are log2(DEPTH) bits with natural wrap; occupancy is tracked by a separate counter.

Decomposition:
- Shared package / define file:
  - ADDR_W/INST_W defaults, aligned with the existing InstAddrBus/InstBus widths.
  - RstEnable/RstDisable values.
  - State encodings IDLE=2'd0, RUN=2'd1, REDIR=2'd2.
  - ChipEnable/ChipDisable values.
- One sub-module: if_id_fifo. This is a synchronous DEPTH x (ADDR_W+INST_W) FIFO with push, pop, flush, count, full and empty.
- The top holds the PC, the FSM and fetch gating.

Test Plan:
- Reset then release with id_ready=1 held → imem_ce low in the IDLE cycle; fetches at 0x0, 0x4, 0x8. id_pc sequence 0x0, 0x4, 0x8 with one-cycle lag; q_count stays 1.
- id_ready=0 from release → exactly 4 fetches (0x0–0xC), then imem_ce=0 and pc=0x10 held. Then id_ready=1 for one cycle → id_pc=0x0 consumed, fetch 0x10 same cycle, q_count stays 4.
- Queue holding 0x0–0x8, redirect_valid=1 with redirect_pc=0x100 and handshake in the same cycle → next cycle id_valid=0 and q_count=0. One dead cycle, then imem_addr=0x100; first id_pc=0x100.
- pc=0xFFFFFFFC with PC_STEP=4 → fetch 0xFFFFFFFC then 0x00000000; id_pc shows both in order.
- fetch_en=0 for 5 cycles with 3 entries and id_ready=1 → queue drains to empty, pc frozen. Re-enable → fetch resumes at the frozen pc with no gap or duplicate.
- rstn=1 asserted while full and redirect_valid=1 → next cycle pc=RESET_PC, q_count=0, id_valid=0, imem_ce=0.
